tedv3_architecture_nios2_oci_dct_monitor: RTL and testbench

TEDV3_ARCHITECTURE_NIOS2_OCI_DCT_MONITOR -- requirements
Module: tedv3_architecture_nios2_oci_dct_monitor

---
 rtl/tedv3_oci_dct_pkg.sv | 19 +
 rtl/tedv3_oci_dct_fifo.sv | 72 +++++++
 rtl/tedv3_architecture_nios2_oci_dct_monitor.sv | 149 ++++++++++++++
 tb/tb_tedv3_architecture_nios2_oci_dct_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tedv3_oci_dct_pkg.sv
// Shared definitions for the OCI data-trace capture monitor.
// Holds the monitor state encoding, the default parameter values used by the
// top module, and the width of the 16-bit statistics counters.
package tedv3_oci_dct_pkg;

    // Capture accepts trace words, drain empties the buffer without accepting
    // new words, ended holds until the test is restarted.
    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ENDED   = 2'd2
    } dct_state_e;

    localparam int DATA_W_DEFAULT = 30;
    localparam int CNT_W_DEFAULT  = 4;
    localparam int DEPTH_DEFAULT  = 16;
    localparam int CTR_W          = 16;

endpackage : tedv3_oci_dct_pkg

// File: rtl/tedv3_oci_dct_fifo.sv
// Storage for captured trace words.
// A DEPTH-entry circular buffer with read/write pointers and an occupancy
// counter. The head entry is presented combinationally from storage once it
// has been written, so a word pushed into an empty buffer appears on the
// following cycle.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   push_i, wdata_i  write request and word (caller guarantees room)
//   pop_i            remove head entry (caller guarantees non-empty)
//   rdata_o          head entry, zero while empty
//   full_o, empty_o  occupancy flags
//   level_o          number of stored entries, 0..DEPTH
module tedv3_oci_dct_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;

    // Storage is deliberately left unreset; an empty buffer masks its contents.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    assign full_o  = (level_q == LVL_FULL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

endmodule : tedv3_oci_dct_fifo

// File: rtl/tedv3_architecture_nios2_oci_dct_monitor.sv
// Data-trace capture monitor.
// Buffers (dct_buffer, dct_count) pairs while capturing, tracks dropped
// words and the running sum of counts, and on test_ending stops capturing
// and drains the buffer before reporting test_has_ended.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   dct_valid/dct_buffer/dct_count incoming trace word, dct_ready while capturing
//   test_ending, test_restart     one-cycle control pulses
//   out_valid/out_ready/out_data/out_count  downstream handshake of the head entry
//   level                         buffer occupancy
//   overflow, drop_count          sticky drop flag and saturating drop counter
//   word_total                    wrapping sum of accepted dct_count values
//   test_has_ended                high once draining has completed
module tedv3_architecture_nios2_oci_dct_monitor
    import tedv3_oci_dct_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dct_valid,
    input  logic [DATA_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    output logic                    dct_ready,
    input  logic                    test_ending,
    input  logic                    test_restart,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [CTR_W-1:0]        drop_count,
    output logic [CTR_W-1:0]        word_total,
    output logic                    test_has_ended
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    dct_state_e        state_q, state_d;
    logic              overflow_q, overflow_d;
    logic [CTR_W-1:0]  dropCount_q, dropCount_d;
    logic [CTR_W-1:0]  wordTotal_q, wordTotal_d;

    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [LVL_W-1:0]        fifoLevel;
    logic [CNT_W+DATA_W-1:0] fifoRdata;
    logic                    isCapture;
    logic                    wordOffered;
    logic                    push;
    logic                    pop;
    logic                    drop;

    assign isCapture   = (state_q == ST_CAPTURE);
    assign pop         = out_valid && out_ready;
    // Zero-count words carry nothing and are discarded without being counted.
    assign wordOffered = dct_valid && isCapture && (dct_count != '0);
    // A full buffer still accepts a word when the head leaves on the same cycle.
    assign push        = wordOffered && (!fifoFull || pop);
    assign drop        = wordOffered && fifoFull && !pop;

    tedv3_oci_dct_fifo #(
        .WIDTH (CNT_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({dct_count, dct_buffer}),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // Next-state and statistics update. Draining completes either when the
    // buffer is already empty or on the cycle that pops its last entry, so
    // test_has_ended rises together with level reaching zero.
    always_comb begin
        state_d     = state_q;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;
        wordTotal_d = wordTotal_q;

        case (state_q)
            ST_CAPTURE: begin
                if (test_ending) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifoEmpty || (fifoLevel == LVL_ONE && pop)) begin
                    state_d = ST_ENDED;
                end
            end
            ST_ENDED: begin
                if (test_restart) begin
                    state_d     = ST_CAPTURE;
                    overflow_d  = 1'b0;
                    dropCount_d = '0;
                    wordTotal_d = '0;
                end
            end
            default: state_d = ST_CAPTURE;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (dropCount_q != '1) begin
                dropCount_d = dropCount_q + CTR_ONE;
            end
        end
        if (push) begin
            wordTotal_d = wordTotal_q + CTR_W'(dct_count);
        end
    end

    // State and counter registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CAPTURE;
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
            wordTotal_q <= '0;
        end else begin
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
            wordTotal_q <= wordTotal_d;
        end
    end

    assign dct_ready      = isCapture;
    assign out_valid      = !fifoEmpty;
    assign out_data       = fifoRdata[DATA_W-1:0];
    assign out_count      = fifoRdata[CNT_W+DATA_W-1:DATA_W];
    assign level          = fifoLevel;
    assign overflow       = overflow_q;
    assign drop_count     = dropCount_q;
    assign word_total     = wordTotal_q;
    assign test_has_ended = (state_q == ST_ENDED);

endmodule : tedv3_architecture_nios2_oci_dct_monitor

// File: tb/tb_tedv3_architecture_nios2_oci_dct_monitor.sv
// Directed bench for the data-trace capture monitor using default parameters
// (DATA_W=30, CNT_W=4, DEPTH=16). Inputs change 1ns after a rising edge and
// outputs are observed at the same point.
module tb_tedv3_architecture_nios2_oci_dct_monitor;

    logic        clk;
    logic        reset;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_ready;
    logic        test_ending;
    logic        test_restart;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] word_total;
    logic        test_has_ended;

    int errors = 0;
    int checks = 0;

    tedv3_architecture_nios2_oci_dct_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_restart   (test_restart),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .level          (level),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .word_total     (word_total),
        .test_has_ended (test_has_ended)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Offer one word for a single cycle.
    task automatic applyStimulus(input logic [29:0] data, input logic [3:0] cnt);
        dct_valid  = 1'b1;
        dct_buffer = data;
        dct_count  = cnt;
        tick();
        dct_valid  = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL rst_level got=%0d exp=0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_drop got=%0d exp=0", drop_count); end
        checks++; if (word_total !== 16'd0) begin errors++; $display("[TB] FAIL rst_total got=%0d exp=0", word_total); end
        checks++; if (test_has_ended !== 1'b0) begin errors++; $display("[TB] FAIL rst_ended got=%b exp=0", test_has_ended); end
        checks++; if (dct_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got=%b exp=1", dct_ready); end
        checks++; if (out_data !== 30'd0 || out_count !== 4'd0) begin errors++; $display("[TB] FAIL rst_outdata got=%h/%0d exp=0/0", out_data, out_count); end
    endtask

    task automatic test_basic_order();
        logic [29:0] expData [3];
        logic [3:0]  expCnt  [3];
        expData[0] = 30'h0AAA_0001; expCnt[0] = 4'd2;
        expData[1] = 30'h0BBB_0002; expCnt[1] = 4'd5;
        expData[2] = 30'h0CCC_0003; expCnt[2] = 4'd1;
        doReset();
        out_ready = 1'b0;
        applyStimulus(expData[0], expCnt[0]);
        checks++; if (out_valid !== 1'b1 || level !== 5'd1) begin errors++; $display("[TB] FAIL basic_latency valid=%b level=%0d exp=1/1", out_valid, level); end
        applyStimulus(expData[1], expCnt[1]);
        applyStimulus(expData[2], expCnt[2]);
        checks++; if (level !== 5'd3) begin errors++; $display("[TB] FAIL basic_level got=%0d exp=3", level); end
        checks++; if (word_total !== 16'd8) begin errors++; $display("[TB] FAIL basic_total got=%0d exp=8", word_total); end
        tick();
        checks++; if (out_data !== expData[0] || level !== 5'd3) begin errors++; $display("[TB] FAIL basic_stall got=%h lvl=%0d exp=%h lvl=3", out_data, level, expData[0]); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_data !== expData[i] || out_count !== expCnt[i]) begin
                errors++;
                $display("[TB] FAIL basic_pop%0d got=%h/%0d exp=%h/%0d", i, out_data, out_count, expData[i], expCnt[i]);
            end
            tick();
        end
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty lvl=%0d valid=%b exp=0/0", level, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        int expTotal = 0;
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(30'd100 + 30'(i), 4'((i % 15) + 1));
            if (i < 16) expTotal += (i % 15) + 1;
        end
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=16", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("[TB] FAIL ovf_drop got=%0d exp=2", drop_count); end
        checks++; if (word_total !== 16'(expTotal)) begin errors++; $display("[TB] FAIL ovf_total got=%0d exp=%0d", word_total, expTotal); end
        // Full buffer: push and pop together.
        out_ready = 1'b1;
        checks++; if (out_data !== 30'd100) begin errors++; $display("[TB] FAIL full_head got=%0d exp=100", out_data); end
        applyStimulus(30'd500, 4'd3);
        expTotal += 3;
        checks++; if (level !== 5'd16) begin errors++; $display("[TB] FAIL full_pushpop_level got=%0d exp=16", level); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("[TB] FAIL full_pushpop_drop got=%0d exp=2", drop_count); end
        checks++; if (word_total !== 16'(expTotal)) begin errors++; $display("[TB] FAIL full_pushpop_total got=%0d exp=%0d", word_total, expTotal); end
        for (int i = 1; i < 17; i++) begin
            logic [29:0] expD;
            expD = (i < 16) ? 30'd100 + 30'(i) : 30'd500;
            checks++;
            if (out_data !== expD) begin errors++; $display("[TB] FAIL ovf_order%0d got=%0d exp=%0d", i, out_data, expD); end
            tick();
        end
        checks++; if (level !== 5'd0) begin errors++; $display("[TB] FAIL ovf_drained got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_count_zero();
        doReset();
        out_ready = 1'b0;
        applyStimulus(30'h55, 4'd3);
        applyStimulus(30'h66, 4'd0);
        checks++; if (level !== 5'd1) begin errors++; $display("[TB] FAIL zero_level got=%0d exp=1", level); end
        checks++; if (word_total !== 16'd3 || drop_count !== 16'd0) begin errors++; $display("[TB] FAIL zero_counters total=%0d drop=%0d exp=3/0", word_total, drop_count); end
        out_ready = 1'b1;
        checks++; if (out_data !== 30'h55) begin errors++; $display("[TB] FAIL zero_head got=%h exp=55", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_nostore got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        doReset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(30'h200 + 30'(i), 4'd1);
            checks++;
            if (level !== 5'd1 || out_data !== 30'h200 + 30'(i)) begin
                errors++;
                $display("[TB] FAIL b2b_%0d lvl=%0d data=%h exp=1/%h", i, level, out_data, 30'h200 + 30'(i));
            end
        end
        tick();
        checks++; if (level !== 5'd0 || word_total !== 16'd5) begin errors++; $display("[TB] FAIL b2b_end lvl=%0d total=%0d exp=0/5", level, word_total); end
        out_ready = 1'b0;
    endtask

    task automatic test_drain();
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(30'h100 + 30'(i), 4'(i + 1));
        test_ending = 1'b1;
        applyStimulus(30'h104, 4'd5);
        test_ending = 1'b0;
        checks++; if (level !== 5'd5 || word_total !== 16'd15) begin errors++; $display("[TB] FAIL drain_lastpush lvl=%0d total=%0d exp=5/15", level, word_total); end
        checks++; if (dct_ready !== 1'b0) begin errors++; $display("[TB] FAIL drain_ready got=%b exp=0", dct_ready); end
        applyStimulus(30'h1FF, 4'd7);
        checks++; if (level !== 5'd5 || drop_count !== 16'd0) begin errors++; $display("[TB] FAIL drain_ignore lvl=%0d drop=%0d exp=5/0", level, drop_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_data !== 30'h100 + 30'(i)) begin errors++; $display("[TB] FAIL drain_pop%0d got=%h exp=%h", i, out_data, 30'h100 + 30'(i)); end
            tick();
            if (i == 3) begin
                checks++; if (test_has_ended !== 1'b0) begin errors++; $display("[TB] FAIL drain_early got=%b exp=0", test_has_ended); end
            end
        end
        checks++; if (test_has_ended !== 1'b1 || level !== 5'd0) begin errors++; $display("[TB] FAIL drain_ended got=%b lvl=%0d exp=1/0", test_has_ended, level); end
        out_ready = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (test_has_ended !== 1'b1) begin errors++; $display("[TB] FAIL ended_hold got=%b exp=1", test_has_ended); end
        test_restart = 1'b1;
        tick();
        test_restart = 1'b0;
        checks++; if (test_has_ended !== 1'b0 || dct_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_state ended=%b ready=%b exp=0/1", test_has_ended, dct_ready); end
        checks++; if (word_total !== 16'd0) begin errors++; $display("[TB] FAIL restart_total got=%0d exp=0", word_total); end
    endtask

    task automatic test_restart_clears();
        bit ended = 1'b0;
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) applyStimulus(30'h300 + 30'(i), 4'd2);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && !ended; n++) begin
            tick();
            ended = test_has_ended;
        end
        out_ready = 1'b0;
        checks++; if (!ended) begin errors++; $display("[TB] FAIL restart_timeout ended=%b exp=1", test_has_ended); end
        checks++; if (overflow !== 1'b1 || drop_count !== 16'd1 || word_total !== 16'd32) begin errors++; $display("[TB] FAIL ended_counters ovf=%b drop=%0d total=%0d exp=1/1/32", overflow, drop_count, word_total); end
        test_restart = 1'b1;
        tick();
        test_restart = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_count !== 16'd0 || word_total !== 16'd0) begin errors++; $display("[TB] FAIL restart_clear ovf=%b drop=%0d total=%0d exp=0/0/0", overflow, drop_count, word_total); end
    endtask

    task automatic test_reset_in_drain();
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(30'h400 + 30'(i), 4'd1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++; if (level !== 5'd5 || dct_ready !== 1'b0) begin errors++; $display("[TB] FAIL predrain lvl=%0d ready=%b exp=5/0", level, dct_ready); end
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b0;
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drainrst_fifo lvl=%0d valid=%b exp=0/0", level, out_valid); end
        checks++; if (dct_ready !== 1'b1 || test_has_ended !== 1'b0) begin errors++; $display("[TB] FAIL drainrst_state ready=%b ended=%b exp=1/0", dct_ready, test_has_ended); end
    endtask

    initial begin
        reset        = 1'b1;
        dct_valid    = 1'b0;
        dct_buffer   = '0;
        dct_count    = '0;
        test_ending  = 1'b0;
        test_restart = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic_order();
        test_overflow();
        test_count_zero();
        test_back_to_back();
        test_drain();
        test_restart_clears();
        test_reset_in_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_tedv3_architecture_nios2_oci_dct_monitor
